// File: rtl/serial_tx_fifo_if.sv
// Bus-side bundle of serial_tx_fifo: word push handshake, per-frame
// configuration, serial output and status. The front-end takes the master
// view, the transmitter takes the slave view.
interface serial_tx_fifo_if #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [SIZE-1:0]  DataIn;
    logic             Sample;
    logic             Ready;
    logic             StartTx;
    logic             LsbFirst;
    logic             ParityEn;
    logic             OddParity;
    logic [DIV_W-1:0] BitDiv;
    logic             Dout;
    logic             TxBusy;
    logic             TxDone;
    logic [LVL_W-1:0] Level;
    logic             Overflow;

    modport master (
        output DataIn, Sample, StartTx, LsbFirst, ParityEn, OddParity, BitDiv,
        input  Ready, Dout, TxBusy, TxDone, Level, Overflow
    );

    modport slave (
        input  DataIn, Sample, StartTx, LsbFirst, ParityEn, OddParity, BitDiv,
        output Ready, Dout, TxBusy, TxDone, Level, Overflow
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// Buffered serial transmitter: a DEPTH-word FIFO feeding a shift register
// that serialises one word per frame on Dout. Bit order, optional parity
// and bit period are captured when a frame starts and held for its length.
module serial_tx_fifo #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    serial_tx_fifo_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int CW    = $clog2(SIZE);
    localparam logic [CW-1:0]    LAST_BIT = CW'(SIZE - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;

    // FIFO storage and bookkeeping
    logic [SIZE-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;

    // Frame engine
    state_e           state_q, state_d;
    logic [SIZE-1:0]  shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] bit_div_q, bit_div_d;
    logic             lsb_first_q, lsb_first_d;
    logic             par_en_q, par_en_d;
    logic             parity_q, parity_d;
    logic             done_q, done_d;

    logic full;
    logic push;
    logic pop;

    // Full, push and pop all look at the pre-pop level, so a push that
    // coincides with a pop while full is still rejected.
    assign full = (level_q == FULL_LVL);
    assign push = bus.Sample && !full;
    assign pop  = (state_q == IDLE) && bus.StartTx && (level_q != '0);

    // Word storage: written on an accepted push only.
    // NOTE: the array has no reset; reset empties the FIFO through the
    // pointers and level, so stale words are never read back.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.DataIn;
        end
    end

    // Next pointers, occupancy and the sticky overflow flag.
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q;
        overflow_d = overflow_q | (bus.Sample & full);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO state register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame sequencing: start on a queued word, count bit periods, shift,
    // optionally append parity, then flag completion for one cycle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        bit_div_d   = bit_div_q;
        lsb_first_d = lsb_first_q;
        par_en_d    = par_en_q;
        parity_d    = parity_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d     = mem_q[rd_ptr_q];
                    lsb_first_d = bus.LsbFirst;
                    par_en_d    = bus.ParityEn;
                    parity_d    = (^mem_q[rd_ptr_q]) ^ bus.OddParity;
                    bit_div_d   = bus.BitDiv;
                    div_d       = bus.BitDiv;
                    bit_cnt_d   = '0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (div_q == '0) begin
                    div_d = bit_div_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        shift_d   = lsb_first_q ? (shift_q >> 1) : (shift_q << 1);
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            PARITY: begin
                if (div_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame engine state register; reset aborts any frame in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            bit_div_q   <= '0;
            lsb_first_q <= 1'b0;
            par_en_q    <= 1'b0;
            parity_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            bit_div_q   <= bit_div_d;
            lsb_first_q <= lsb_first_d;
            par_en_q    <= par_en_d;
            parity_q    <= parity_d;
            done_q      <= done_d;
        end
    end

    // Serial line: current data bit, parity bit, or 0 while idle.
    always_comb begin
        bus.Dout = 1'b0;
        if (state_q == DATA) begin
            bus.Dout = lsb_first_q ? shift_q[0] : shift_q[SIZE-1];
        end else if (state_q == PARITY) begin
            bus.Dout = parity_q;
        end
    end

    assign bus.TxBusy   = (state_q != IDLE);
    assign bus.TxDone   = done_q;
    assign bus.Ready    = !full;
    assign bus.Level    = level_q;
    assign bus.Overflow = overflow_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench for serial_tx_fifo: accepted words are queued when
// pushed; a negedge monitor pops one per frame, rebuilds the expected
// Dout waveform from the configuration present in the start cycle and
// compares it cycle by cycle.
module tb_serial_tx_fifo;
    localparam int SIZE  = 32;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic Clk = 1'b0;
    logic Reset_n;

    serial_tx_fifo_if #(.SIZE(SIZE), .DEPTH(DEPTH), .DIV_W(DIV_W)) bus();

    serial_tx_fifo #(.SIZE(SIZE), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [SIZE-1:0] sb [$];
    int lens [$];

    // monitor state
    bit               in_frame = 0;
    int               cyc, exp_len, period, errs;
    logic [SIZE:0]    seq_bits;
    logic [SIZE-1:0]  word;
    int               started = 0, frames_done = 0, done_cnt = 0;
    int               gap = 0, last_gap = 0, idle_errs = 0, stray_done = 0;
    bit               just_ended = 0;
    logic             snap_lsb, snap_pe, snap_odd;
    logic [DIV_W-1:0] snap_div;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor and scoreboard consumer.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            in_frame   = 0;
            just_ended = 0;
            gap        = 0;
        end else begin
            if (bus.TxDone) done_cnt++;
            if (bus.TxBusy) begin
                if (!in_frame) begin
                    check("sb_has_word", sb.size() != 0, 1'b1);
                    word = (sb.size() != 0) ? sb.pop_front() : '0;
                    for (int i = 0; i < SIZE; i++)
                        seq_bits[i] = snap_lsb ? word[i] : word[SIZE-1-i];
                    seq_bits[SIZE] = (^word) ^ snap_odd;
                    period   = int'(snap_div) + 1;
                    exp_len  = (SIZE + (snap_pe ? 1 : 0)) * period;
                    in_frame = 1;
                    cyc      = 0;
                    errs     = 0;
                    last_gap = gap;
                    started++;
                end
                if (cyc >= exp_len || bus.Dout !== seq_bits[cyc / period]) errs++;
                if (bus.TxDone) errs++;
                cyc++;
                just_ended = 0;
            end else begin
                if (bus.Dout !== 1'b0) idle_errs++;
                if (in_frame) begin
                    check("frame_len", cyc, exp_len);
                    check("frame_dout_errs", errs, 0);
                    check("txdone_after_frame", bus.TxDone, 1'b1);
                    lens.push_back(cyc);
                    in_frame = 0;
                    frames_done++;
                    gap = 1;
                end else begin
                    if (bus.TxDone) stray_done++;
                    gap++;
                end
            end
        end
        snap_lsb = bus.LsbFirst;
        snap_pe  = bus.ParityEn;
        snap_odd = bus.OddParity;
        snap_div = bus.BitDiv;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [SIZE-1:0] w, input bit accept);
        check("ready_at_push", bus.Ready, accept);
        bus.DataIn = w;
        bus.Sample = 1'b1;
        if (accept) sb.push_back(w);
        tick(1);
        bus.Sample = 1'b0;
    endtask

    task automatic set_cfg(input logic lsb, input logic pe, input logic odd, input int div);
        bus.LsbFirst  = lsb;
        bus.ParityEn  = pe;
        bus.OddParity = odd;
        bus.BitDiv    = DIV_W'(div);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick(1);
            n++;
        end
        check("frames_in_time", frames_done >= target, 1'b1);
    endtask

    task automatic wait_started(input int target, input int budget);
        int n = 0;
        while (started < target && n < budget) begin
            tick(1);
            n++;
        end
        check("start_in_time", started >= target, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, f0;
        Reset_n     = 1'b0;
        bus.DataIn  = '0;
        bus.Sample  = 1'b0;
        bus.StartTx = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 0);
        #23;
        check("rst_dout", bus.Dout, 1'b0);
        check("rst_busy", bus.TxBusy, 1'b0);
        check("rst_done", bus.TxDone, 1'b0);
        check("rst_level", bus.Level, 0);
        check("rst_ovf", bus.Overflow, 1'b0);
        check("rst_ready", bus.Ready, 1'b1);
        Reset_n = 1'b1;
        tick(2);

        // 1: MSB first, one cycle per bit, no parity
        push_word(32'hA5A5_0F0F, 1'b1);
        check("t1_level_after_push", bus.Level, 1);
        bus.StartTx = 1'b1;
        wait_frames(1, 100);
        check("t1_len", lens[lens.size()-1], 32);
        check("t1_level_end", bus.Level, 0);
        check("t1_ovf", bus.Overflow, 1'b0);

        // 2: LSB first, 4-cycle bits, even parity
        set_cfg(1'b1, 1'b1, 1'b0, 3);
        push_word(32'h0000_0007, 1'b1);
        wait_frames(2, 300);
        check("t2_len", lens[lens.size()-1], 132);

        // 3: fill, overflow on push coinciding with the first pop, drain
        bus.StartTx = 1'b0;
        set_cfg(1'b0, 1'b1, 1'b1, 1);
        tick(2);
        push_word(32'h1234_5678, 1'b1);
        push_word(32'h8000_0001, 1'b1);
        push_word(32'hFFFF_FFFF, 1'b1);
        push_word(32'h0F0F_F0F0, 1'b1);
        check("t3_level_full", bus.Level, 4);
        check("t3_ready_full", bus.Ready, 1'b0);
        bus.StartTx = 1'b1;
        push_word(32'hDEAD_BEEF, 1'b0);
        check("t3_ovf", bus.Overflow, 1'b1);
        wait_frames(6, 400);
        check("t3_gap", last_gap, 1);
        check("t3_level_end", bus.Level, 0);
        check("t3_ovf_sticky", bus.Overflow, 1'b1);
        check("t3_done_cnt", done_cnt, 6);

        // 4: asynchronous reset in the middle of a frame
        bus.StartTx = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 0);
        push_word(32'h5555_AAAA, 1'b1);
        push_word(32'h3C3C_3C3C, 1'b1);
        s0 = started;
        bus.StartTx = 1'b1;
        wait_started(s0 + 1, 20);
        tick(9);
        #2;
        Reset_n = 1'b0;
        sb.delete();
        #1;
        check("t4_dout", bus.Dout, 1'b0);
        check("t4_busy", bus.TxBusy, 1'b0);
        check("t4_level", bus.Level, 0);
        check("t4_ovf", bus.Overflow, 1'b0);
        tick(2);
        #2;
        Reset_n = 1'b1;
        tick(40);
        check("t4_no_restart", started, s0 + 1);
        check("t4_no_done", done_cnt, 6);
        check("t4_busy_after", bus.TxBusy, 1'b0);

        // 5: StartTx dropped during the first of two queued frames
        bus.StartTx = 1'b0;
        set_cfg(1'b1, 1'b0, 1'b0, 1);
        push_word(32'hCAFE_F00D, 1'b1);
        push_word(32'h0BAD_1DEA, 1'b1);
        s0 = started;
        f0 = frames_done;
        bus.StartTx = 1'b1;
        wait_started(s0 + 1, 20);
        tick(5);
        bus.StartTx = 1'b0;
        wait_frames(f0 + 1, 100);
        tick(20);
        check("t5_level_held", bus.Level, 1);
        check("t5_no_start", started, s0 + 1);
        check("t5_idle_dout", bus.Dout, 1'b0);
        bus.StartTx = 1'b1;
        wait_frames(f0 + 2, 100);
        check("t5_level_end", bus.Level, 0);

        // 6: BitDiv changed mid-frame only affects the next frame
        bus.StartTx = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, 1);
        push_word(32'h8765_4321, 1'b1);
        push_word(32'h1357_9BDF, 1'b1);
        s0 = started;
        f0 = frames_done;
        bus.StartTx = 1'b1;
        wait_started(s0 + 1, 20);
        tick(10);
        bus.BitDiv = DIV_W'(5);
        wait_frames(f0 + 2, 400);
        check("t6_len_first", lens[lens.size()-2], 64);
        check("t6_len_second", lens[lens.size()-1], 192);

        tick(3);
        check("final_sb_empty", sb.size(), 0);
        check("final_done_cnt", done_cnt, 10);
        check("final_stray_done", stray_done, 0);
        check("final_idle_dout", idle_errs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
